fibonacci_ctrl: RTL and testbench

Control unit for the fibonacci datapath. It accepts a start request with an iteration count N and drives the datapath enables (enable_reg1, enable_reg2, enable_regN, enable_count) plus the init-load and counter-clear strobes. It monitors the datapath comparator and returns the final FIB_SAIDA value through a valid/ack result handshake. A step watchdog flags a datapath that never reaches N.

---
 rtl/fibonacci_ctrl.sv | 113 +++++++++++
 tb/tb_fibonacci_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fibonacci_ctrl.sv
// rtl/fibonacci_ctrl.sv - control FSM for the fibonacci datapath with result handshake and step watchdog
module fibonacci_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] N_in,
    input  logic [WIDTH-1:0] saida_do_comparador,
    input  logic [WIDTH-1:0] FIB_SAIDA,
    output logic             enable_reg1,
    output logic             enable_reg2,
    output logic             enable_regN,
    output logic             enable_count,
    output logic             load_init,
    output logic             clear_count,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADN,
        S_INIT,
        S_STEP,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] n_q;
    logic [7:0]       step_cnt;
    logic             cmp_hit;
    logic             wd_hit;
    logic             unused_cmp_bits;

    assign cmp_hit         = saida_do_comparador[0];
    assign wd_hit          = (step_cnt == TIMEOUT_C);
    assign unused_cmp_bits = ^saida_do_comparador[WIDTH-1:1];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOADN;
            S_LOADN: state_nxt = (n_q == '0) ? S_DONE : S_INIT;
            S_INIT:  state_nxt = S_STEP;
            S_STEP:  state_nxt = S_CHECK;
            // comparator wins over the watchdog when both fire together
            S_CHECK: begin
                if (cmp_hit)     state_nxt = S_DONE;
                else if (wd_hit) state_nxt = S_ERR;
                else             state_nxt = S_STEP;
            end
            S_DONE:  if (result_ack) state_nxt = S_IDLE;
            S_ERR:   if (result_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            n_q          <= '0;
            step_cnt     <= '0;
            result       <= '0;
            enable_reg1  <= 1'b0;
            enable_reg2  <= 1'b0;
            enable_regN  <= 1'b0;
            enable_count <= 1'b0;
            load_init    <= 1'b0;
            clear_count  <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nxt;
            enable_reg1  <= (state_nxt == S_INIT) || (state_nxt == S_STEP);
            enable_reg2  <= (state_nxt == S_INIT) || (state_nxt == S_STEP);
            enable_regN  <= (state_nxt == S_LOADN);
            enable_count <= (state_nxt == S_STEP);
            load_init    <= (state_nxt == S_INIT);
            clear_count  <= (state_nxt == S_INIT);
            busy         <= (state_nxt != S_IDLE);
            result_valid <= (state_nxt == S_DONE) || (state_nxt == S_ERR);
            error        <= (state_nxt == S_ERR);

            if (state == S_IDLE && start) begin
                n_q      <= N_in;
                step_cnt <= '0;
            end
            if (state == S_STEP && step_cnt != 8'hFF) begin
                step_cnt <= step_cnt + 8'd1;
            end
            if (state == S_LOADN && n_q == '0) begin
                result <= '0;
            end
            if (state == S_CHECK) begin
                if (cmp_hit)     result <= FIB_SAIDA;
                else if (wd_hit) result <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fibonacci_ctrl.sv
// tb/tb_fibonacci_ctrl.sv - scoreboard bench for fibonacci_ctrl with a datapath model
module tb_fibonacci_ctrl;

    localparam int W  = 8;
    localparam int TO = 12;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] N_in;
    logic [W-1:0] saida_do_comparador;
    logic [W-1:0] FIB_SAIDA;
    logic         enable_reg1, enable_reg2, enable_regN, enable_count;
    logic         load_init, clear_count, busy, result_valid, result_ack, error;
    logic [W-1:0] result;

    fibonacci_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .N_in(N_in),
        .saida_do_comparador(saida_do_comparador), .FIB_SAIDA(FIB_SAIDA),
        .enable_reg1(enable_reg1), .enable_reg2(enable_reg2),
        .enable_regN(enable_regN), .enable_count(enable_count),
        .load_init(load_init), .clear_count(clear_count), .busy(busy),
        .result(result), .result_valid(result_valid),
        .result_ack(result_ack), .error(error)
    );

    always #5 clock = ~clock;

    // Datapath model: reg1/reg2 fibonacci pair, step counter, N register, equality comparator.
    logic [W-1:0] r1, r2, cnt, rn;
    logic [6:0]   junk;
    logic         broken;

    always @(posedge clock) begin
        if (reset) begin
            r1 <= '0; r2 <= '0; cnt <= '0; rn <= '0;
        end else begin
            if (enable_regN) rn <= N_in;
            if (load_init) begin
                r1 <= 8'd1; r2 <= 8'd1;
            end else if (enable_reg1 && enable_reg2) begin
                r1 <= r2; r2 <= r1 + r2;
            end
            if (clear_count)       cnt <= '0;
            else if (enable_count) cnt <= cnt + 8'd1;
        end
    end

    assign saida_do_comparador = {junk, (cnt == rn) && !broken};
    assign FIB_SAIDA           = r1;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           steps;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t ref_model(input int n, input bit brk);
        exp_t e;
        int a, b, t;
        if (n == 0) begin
            e.res = '0; e.err = 1'b0; e.steps = 0; e.lat = 2;
        end else if (brk || n > TO) begin
            e.res = '0; e.err = 1'b1; e.steps = TO; e.lat = 2 * TO + 3;
        end else begin
            a = 1; b = 1;
            repeat (n) begin
                t = (a + b) % 256; a = b; b = t;
            end
            e.res = a[W-1:0]; e.err = 1'b0; e.steps = n; e.lat = 2 * n + 3;
        end
        return e;
    endfunction

    // Monitor: counts busy cycles and STEP pulses per run, checks on result_valid.
    int           mon_lat = 0;
    int           mon_steps = 0;
    bit           in_valid = 0;
    logic [W-1:0] held_res;
    logic         held_err;

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!busy && !result_valid) begin
                mon_lat = 0; mon_steps = 0; in_valid = 0;
            end else begin
                if (busy) mon_lat++;
                if (enable_count) mon_steps++;
                if (result_valid && !in_valid) begin
                    in_valid = 1;
                    held_res = result;
                    held_err = error;
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", result, e.res);
                        check("error", error, e.err);
                        check("step_pulses", mon_steps, e.steps);
                        check("latency", mon_lat, e.lat);
                    end
                end else if (result_valid) begin
                    check("result_hold", result, held_res);
                    check("error_hold", error, held_err);
                end
            end
        end
    end

    task automatic run(input int n, input bit brk, input int hold);
        int guard;
        @(negedge clock);
        N_in = n[W-1:0]; broken = brk; start = 1'b1;
        exp_q.push_back(ref_model(n, brk));
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        guard = 0;
        while (!result_valid && guard < 1000) begin
            N_in = W'($urandom); junk = 7'($urandom);
            @(negedge clock);
            guard++;
        end
        if (guard >= 1000) check("valid_timeout", result_valid, 1);
        repeat ((hold < 0) ? $urandom_range(0, 4) : hold) begin
            N_in = W'($urandom); junk = 7'($urandom);
            @(negedge clock);
        end
        result_ack = 1'b1; start = 1'b1; N_in = W'($urandom);
        @(negedge clock);
        result_ack = 1'b0; start = 1'b0;
        check("busy_after_ack", busy, 0);
        check("valid_after_ack", result_valid, 0);
        @(negedge clock);
        check("start_in_ack_ignored", busy, 0);
    endtask

    initial begin
        int seen;
        int guard;
        logic any_en;
        reset = 1'b1; start = 1'b0; N_in = '0; result_ack = 1'b0; broken = 1'b0; junk = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_ctrl", {enable_reg1, enable_reg2, enable_regN, enable_count, load_init,
                             clear_count, busy, result_valid, error}, 0);
        check("reset_result", result, 0);
        reset = 1'b0;

        any_en = 1'b0;
        repeat (10) begin
            @(negedge clock);
            any_en |= enable_reg1 | enable_reg2 | enable_regN | enable_count |
                      load_init | clear_count | busy | result_valid;
        end
        check("idle_quiet", any_en, 0);

        run(4, 0, 20);
        run(0, 0, 1);
        run(1, 0, 0);
        run(TO, 0, -1);
        run(TO + 1, 0, -1);
        run(3, 1, -1);

        // Abort during the third STEP; no result may follow.
        @(negedge clock);
        N_in = 8'd10; broken = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        seen = 0; guard = 0;
        while (seen < 3 && guard < 100) begin
            @(negedge clock);
            if (enable_count) seen++;
            guard++;
        end
        check("third_step_seen", seen, 3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrun_reset_ctrl", {enable_reg1, enable_reg2, enable_regN, enable_count, load_init,
                                    clear_count, busy, result_valid, error}, 0);
        run(2, 0, -1);

        repeat (25) run($urandom_range(0, TO + 3), ($urandom_range(0, 7) == 0), -1);

        repeat (5) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
